// File: rtl/mac_row_dual.sv
// mac_row_dual
//   A row of `col` dual-mode MAC tiles. Each tile either runs weight-stationary
//   (WS: c = psum_in + a*b) or output-stationary (OS: c += a*b). Instructions
//   and activations ripple east one tile per cycle. Weights are loaded
//   first-come-first-served: the first free tile that sees a load keeps that
//   value. A serial drain engine streams the OS accumulators out, east-most
//   tile first, over a valid/ready port.
//
// Ports
//   clk, reset    clock, asynchronous active-high reset
//   mode          0 = WS, 1 = OS (takes effect only while idle and empty)
//   inst_w        bit0 = load weight, bit1 = execute (into tile 0)
//   in_w          activation / weight into tile 0
//   in_n          north psum bus, tile j uses slice j
//   out_s         south psum bus, slice j = accumulator of tile j
//   valid         per tile, a WS result was produced last cycle
//   drain_req     start an OS drain (level)
//   drain_busy    drain engine owns the row; feeder must hold off
//   drain_out     drained accumulator value
//   drain_valid   drain_out is valid
//   drain_ready   consumer accepts drain_out
//   drain_done    one-cycle pulse after the last beat is accepted
module mac_row_dual #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [1:0]             inst_w,
  input  logic [bw-1:0]          in_w,
  input  logic [psum_bw*col-1:0] in_n,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  input  logic                   drain_req,
  output logic                   drain_busy,
  output logic [psum_bw-1:0]     drain_out,
  output logic                   drain_valid,
  input  logic                   drain_ready,
  output logic                   drain_done
);

  localparam int IW = (col > 1) ? $clog2(col) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            mode_q, mode_d;
  logic            done_q, done_d;

  logic [bw-1:0]      a_q [col];
  logic [bw-1:0]      a_d [col];
  logic [bw-1:0]      b_q [col];
  logic [bw-1:0]      b_d [col];
  logic [psum_bw-1:0] c_q [col];
  logic [psum_bw-1:0] c_d [col];
  logic [1:0]         inst_q [col];
  logic [1:0]         inst_d [col];
  logic [col-1:0]     load_ready_q, load_ready_d;
  logic [col-1:0]     valid_q, valid_d;

  logic [1:0]         inst_src [col];
  logic [bw-1:0]      a_src [col];
  logic [psum_bw-1:0] prod [col];
  logic               pipe_empty;
  logic               beat_accept;

  // The row is empty when no tile holds an instruction in flight.
  always_comb begin
    pipe_empty = 1'b1;
    for (int j = 0; j < col; j++) begin
      if (inst_q[j] != 2'b00) pipe_empty = 1'b0;
    end
  end

  // Tile inputs: tile 0 takes the feeder (gated off while draining),
  // every other tile takes its west neighbour's registers.
  always_comb begin
    inst_src[0] = (state_q == S_IDLE) ? inst_w : 2'b00;
    a_src[0]    = in_w;
    for (int j = 1; j < col; j++) begin
      inst_src[j] = inst_q[j-1];
      a_src[j]    = a_q[j-1];
    end
  end

  // Sign-extend both operands to psum width; the product wraps modulo 2^psum_bw.
  always_comb begin
    for (int j = 0; j < col; j++) begin
      prod[j] = $signed({{(psum_bw-bw){a_src[j][bw-1]}}, a_src[j]}) *
                $signed({{(psum_bw-bw){b_q[j][bw-1]}}, b_q[j]});
    end
  end

  // Drain engine: wait for the row to empty, then walk idx from the east end
  // down to tile 0, one accepted beat at a time.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    beat_accept = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pipe_empty) mode_d = mode;
        if (drain_req && mode_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pipe_empty) begin
          state_d = S_DRAIN;
          idx_d   = IW'(col-1);
        end
      end
      S_DRAIN: begin
        if (drain_ready) begin
          beat_accept = 1'b1;
          if (idx_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-tile datapath. A tile that captures a weight consumes the load bit so
  // the next free tile downstream waits for the following load.
  always_comb begin
    load_ready_d = load_ready_q;
    valid_d      = '0;
    for (int j = 0; j < col; j++) begin
      a_d[j]    = a_src[j];
      inst_d[j] = inst_src[j];
      b_d[j]    = b_q[j];
      c_d[j]    = c_q[j];
      if (inst_src[j][0] && load_ready_q[j]) begin
        b_d[j]          = a_src[j];
        load_ready_d[j] = 1'b0;
        inst_d[j][0]    = 1'b0;
      end
      if (inst_src[j][1]) begin
        if (mode_q) begin
          c_d[j] = c_q[j] + prod[j];
        end else begin
          c_d[j]     = in_n[j*psum_bw +: psum_bw] + prod[j];
          valid_d[j] = 1'b1;
        end
      end
      if (beat_accept && (idx_q == IW'(j))) c_d[j] = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      mode_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= '1;
      valid_q      <= '0;
      for (int j = 0; j < col; j++) begin
        a_q[j]    <= '0;
        b_q[j]    <= '0;
        c_q[j]    <= '0;
        inst_q[j] <= 2'b00;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
      valid_q      <= valid_d;
      for (int j = 0; j < col; j++) begin
        a_q[j]    <= a_d[j];
        b_q[j]    <= b_d[j];
        c_q[j]    <= c_d[j];
        inst_q[j] <= inst_d[j];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < col; g++) begin : g_out
      assign out_s[g*psum_bw +: psum_bw] = c_q[g];
    end
  endgenerate

  assign valid       = valid_q;
  assign drain_busy  = (state_q != S_IDLE);
  assign drain_valid = (state_q == S_DRAIN);
  assign drain_out   = (state_q == S_DRAIN) ? c_q[idx_q] : '0;
  assign drain_done  = done_q;

endmodule

// File: tb/tb_mac_row_dual.sv
// tb_mac_row_dual
//   Directed bench for a 4-tile mac_row_dual: weight loading, OS accumulation,
//   OS drain with and without back-pressure, WS psum-through, drain requests
//   ignored in WS, and an asynchronous reset in the middle of a drain.
module tb_mac_row_dual;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int COL     = 4;

  logic                   clk;
  logic                   reset;
  logic                   mode;
  logic [1:0]             inst_w;
  logic [BW-1:0]          in_w;
  logic [PSUM_BW*COL-1:0] in_n;
  logic [PSUM_BW*COL-1:0] out_s;
  logic [COL-1:0]         valid;
  logic                   drain_req;
  logic                   drain_busy;
  logic [PSUM_BW-1:0]     drain_out;
  logic                   drain_valid;
  logic                   drain_ready;
  logic                   drain_done;

  int testCount = 0;
  int failCount = 0;

  mac_row_dual #(.bw(BW), .psum_bw(PSUM_BW), .col(COL)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .inst_w     (inst_w),
    .in_w       (in_w),
    .in_n       (in_n),
    .out_s      (out_s),
    .valid      (valid),
    .drain_req  (drain_req),
    .drain_busy (drain_busy),
    .drain_out  (drain_out),
    .drain_valid(drain_valid),
    .drain_ready(drain_ready),
    .drain_done (drain_done)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the feeder at a negedge and advance to the next negedge.
  task automatic applyStimulus(input logic [1:0] inst, input logic [BW-1:0] a);
    inst_w = inst;
    in_w   = a;
    @(negedge clk);
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [PSUM_BW-1:0] sliceOf(input int j);
    return out_s[j*PSUM_BW +: PSUM_BW];
  endfunction

  logic [PSUM_BW-1:0] got [4];
  int                 beats;
  int                 cycles;
  int                 stalls;
  int                 firstBeat;
  int                 lastBeat;
  bit                 sawWait;
  logic [COL-1:0]     validSeen;

  // Linear directed sequence.
  initial begin
    reset       = 1'b1;
    mode        = 1'b0;
    inst_w      = 2'b00;
    in_w        = '0;
    in_n        = '0;
    drain_req   = 1'b0;
    drain_ready = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("reset_out_s", {31'b0, |out_s}, 32'd0);
    checkOutput("reset_valid", {28'b0, valid}, 32'd0);
    checkOutput("reset_busy", {31'b0, drain_busy}, 32'd0);
    checkOutput("reset_dvalid", {31'b0, drain_valid}, 32'd0);
    checkOutput("reset_dout", {16'b0, drain_out}, 32'd0);
    checkOutput("reset_done", {31'b0, drain_done}, 32'd0);
    reset = 1'b0;

    // Four loads fill tiles 0..3; the fifth (7) falls off the east end.
    applyStimulus(2'b01, 4'd3);
    applyStimulus(2'b01, 4'd1);
    applyStimulus(2'b01, 4'd2);
    applyStimulus(2'b01, 4'hF);
    applyStimulus(2'b01, 4'd7);
    repeat (6) applyStimulus(2'b00, 4'd0);

    // OS accumulation: sum of activations 2+4+5 = 11 times each weight.
    mode = 1'b1;
    applyStimulus(2'b00, 4'd0);
    applyStimulus(2'b10, 4'd2);
    applyStimulus(2'b10, 4'd4);
    applyStimulus(2'b10, 4'd5);
    validSeen = '0;
    for (int k = 0; k < 4; k++) begin
      validSeen = validSeen | valid;
      applyStimulus(2'b00, 4'd0);
    end
    validSeen = validSeen | valid;
    checkOutput("os_tile0", {16'b0, sliceOf(0)}, 32'd33);
    checkOutput("os_tile1", {16'b0, sliceOf(1)}, 32'd11);
    checkOutput("os_tile2", {16'b0, sliceOf(2)}, 32'd22);
    checkOutput("os_tile3", {16'b0, sliceOf(3)}, 32'h0000FFF5);
    checkOutput("os_valid_quiet", {28'b0, validSeen}, 32'd0);

    // Drain with the consumer always ready.
    drain_req   = 1'b1;
    drain_ready = 1'b1;
    beats = 0; cycles = 0; firstBeat = -1; lastBeat = -1; sawWait = 1'b0;
    while (beats < 4 && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (drain_busy && !drain_valid) sawWait = 1'b1;
      if (drain_busy) drain_req = 1'b0;
      if (drain_valid) begin
        got[beats] = drain_out;
        if (beats == 0) firstBeat = cycles;
        lastBeat = cycles;
        beats++;
      end
    end
    checkOutput("d1_beats", beats, 32'd4);
    checkOutput("d1_wait_seen", {31'b0, sawWait}, 32'd1);
    checkOutput("d1_back_to_back", lastBeat - firstBeat, 32'd3);
    checkOutput("d1_beat0", {16'b0, got[0]}, 32'h0000FFF5);
    checkOutput("d1_beat1", {16'b0, got[1]}, 32'd22);
    checkOutput("d1_beat2", {16'b0, got[2]}, 32'd11);
    checkOutput("d1_beat3", {16'b0, got[3]}, 32'd33);
    @(negedge clk);
    checkOutput("d1_done_pulse", {31'b0, drain_done}, 32'd1);
    checkOutput("d1_busy_clear", {31'b0, drain_busy}, 32'd0);
    @(negedge clk);
    checkOutput("d1_done_low", {31'b0, drain_done}, 32'd0);
    checkOutput("d1_cleared", {31'b0, |out_s}, 32'd0);

    // Refill, then drain with two stall cycles after the first beat while the
    // feeder tries to execute (it must be ignored).
    applyStimulus(2'b10, 4'd2);
    applyStimulus(2'b10, 4'd4);
    applyStimulus(2'b10, 4'd5);
    repeat (4) applyStimulus(2'b00, 4'd0);
    drain_req = 1'b1;
    beats = 0; cycles = 0; stalls = 0;
    while (beats < 4 && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (drain_busy) begin
        drain_req = 1'b0;
        inst_w    = 2'b10;
        in_w      = 4'd7;
      end
      if (drain_valid) begin
        if (beats == 1 && stalls < 2) begin
          drain_ready = 1'b0;
          stalls++;
          checkOutput("d2_hold_out", {16'b0, drain_out}, 32'd22);
          checkOutput("d2_hold_valid", {31'b0, drain_valid}, 32'd1);
        end else begin
          drain_ready = 1'b1;
          got[beats]  = drain_out;
          beats++;
          if (beats == 4) begin
            inst_w = 2'b00;
            in_w   = 4'd0;
          end
        end
      end
    end
    inst_w = 2'b00;
    in_w   = 4'd0;
    checkOutput("d2_beats", beats, 32'd4);
    checkOutput("d2_stalls", stalls, 32'd2);
    checkOutput("d2_beat0", {16'b0, got[0]}, 32'h0000FFF5);
    checkOutput("d2_beat1", {16'b0, got[1]}, 32'd22);
    checkOutput("d2_beat2", {16'b0, got[2]}, 32'd11);
    checkOutput("d2_beat3", {16'b0, got[3]}, 32'd33);
    @(negedge clk);
    checkOutput("d2_done_pulse", {31'b0, drain_done}, 32'd1);
    checkOutput("d2_cleared", {31'b0, |out_s}, 32'd0);

    // WS: psum from north plus activation 2 times each weight.
    mode = 1'b0;
    applyStimulus(2'b00, 4'd0);
    in_n = {16'd400, 16'd300, 16'd200, 16'd100};
    applyStimulus(2'b10, 4'd2);
    checkOutput("ws_tile0", {16'b0, sliceOf(0)}, 32'd106);
    checkOutput("ws_valid0", {28'b0, valid}, 32'b0001);
    applyStimulus(2'b00, 4'd0);
    checkOutput("ws_tile1", {16'b0, sliceOf(1)}, 32'd202);
    checkOutput("ws_valid1", {28'b0, valid}, 32'b0010);
    applyStimulus(2'b00, 4'd0);
    checkOutput("ws_tile2", {16'b0, sliceOf(2)}, 32'd304);
    checkOutput("ws_valid2", {28'b0, valid}, 32'b0100);
    applyStimulus(2'b00, 4'd0);
    checkOutput("ws_tile3", {16'b0, sliceOf(3)}, 32'd398);
    checkOutput("ws_valid3", {28'b0, valid}, 32'b1000);
    applyStimulus(2'b00, 4'd0);
    checkOutput("ws_valid_end", {28'b0, valid}, 32'd0);

    // A drain request in WS mode is ignored.
    drain_req = 1'b1;
    applyStimulus(2'b00, 4'd0);
    checkOutput("ws_req_ignored_a", {31'b0, drain_busy}, 32'd0);
    applyStimulus(2'b00, 4'd0);
    checkOutput("ws_req_ignored_b", {31'b0, drain_busy}, 32'd0);
    drain_req = 1'b0;

    // Switch to OS (accumulators kept) and reset during the second beat.
    mode = 1'b1;
    applyStimulus(2'b00, 4'd0);
    drain_req   = 1'b1;
    drain_ready = 1'b1;
    applyStimulus(2'b00, 4'd0);
    checkOutput("rd_wait_busy", {31'b0, drain_busy}, 32'd1);
    checkOutput("rd_wait_novalid", {31'b0, drain_valid}, 32'd0);
    drain_req = 1'b0;
    applyStimulus(2'b00, 4'd0);
    checkOutput("rd_beat0", {16'b0, drain_out}, 32'd398);
    applyStimulus(2'b00, 4'd0);
    checkOutput("rd_beat1", {16'b0, drain_out}, 32'd304);
    mode = 1'b0;
    in_n = '0;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_out_s", {31'b0, |out_s}, 32'd0);
    checkOutput("rst_async_dout", {16'b0, drain_out}, 32'd0);
    checkOutput("rst_async_dvalid", {31'b0, drain_valid}, 32'd0);
    checkOutput("rst_async_busy", {31'b0, drain_busy}, 32'd0);
    checkOutput("rst_async_valid", {28'b0, valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'b00, 4'd0);
    checkOutput("post_rst_busy", {31'b0, drain_busy}, 32'd0);
    checkOutput("post_rst_done", {31'b0, drain_done}, 32'd0);

    // Fresh load sequence after reset, then one WS execute with a=1.
    applyStimulus(2'b01, 4'd5);
    applyStimulus(2'b01, 4'd6);
    applyStimulus(2'b01, 4'd7);
    applyStimulus(2'b01, 4'd1);
    repeat (5) applyStimulus(2'b00, 4'd0);
    applyStimulus(2'b10, 4'd1);
    repeat (4) applyStimulus(2'b00, 4'd0);
    checkOutput("reload_tile0", {16'b0, sliceOf(0)}, 32'd5);
    checkOutput("reload_tile1", {16'b0, sliceOf(1)}, 32'd6);
    checkOutput("reload_tile2", {16'b0, sliceOf(2)}, 32'd7);
    checkOutput("reload_tile3", {16'b0, sliceOf(3)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
